buffer_register_serial: RTL and testbench

- Parametrised successor to the fixed 10-bit buffer register slice.
- Holds one full LVDC-style data word with these load sources:
  - wired-OR merge of N_MOD memory-module sense-amp channels;
  - syllable-gated transfer-register inputs;
  - an active-low clear that breaks recirculation.
- New capabilities:
  - odd-parity check of memory reads;
  - serial LSB-first shift-out mode for the serial arithmetic section.
- Sits between the memory sense amplifiers and the serial arithmetic unit.

---
 rtl/buffer_register_serial.sv | 142 ++++++++++++++
 tb/tb_buffer_register_serial.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_register_serial.sv
// buffer_register_serial
//   One-word buffer register between the memory sense amplifiers and the
//   serial arithmetic unit. In idle it OR-accumulates sense-amp channels and
//   syllable-gated transfer-register data, with an active-low clear that
//   breaks recirculation. It checks odd parity on memory reads and can shift
//   the held word out LSB-first.
//
// Ports
//   CLK, RESET         clock, synchronous active-high reset
//   CBRVN              active-low clear (drops recirculation this cycle)
//   SBRZV / SBRYV      TR load enables for Z / Y syllable bits
//   TR[W]              transfer register data
//   SA[N_MOD*W]        sense-amp data, module m at [m*W +: W]
//   SA_VALID[N_MOD]    per-module sense strobe
//   SA_PAR[N_MOD]      per-module stored parity bit
//   SHIFT              start serial shift-out
//   BR / BRN [W]       contents and complement
//   SER_OUT            serial bit (BR[0] while BUSY, else 0)
//   BUSY / DONE        shift in progress / one-cycle end-of-shift pulse
//   PAR_ERR            sticky parity error
module buffer_register_serial #(
    parameter int             W        = 26,
    parameter int             N_MOD    = 4,
    parameter logic [W-1:0]   SYL_MASK = 26'h3FFE000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CBRVN,
    input  logic               SBRZV,
    input  logic               SBRYV,
    input  logic [W-1:0]       TR,
    input  logic [N_MOD*W-1:0] SA,
    input  logic [N_MOD-1:0]   SA_VALID,
    input  logic [N_MOD-1:0]   SA_PAR,
    input  logic               SHIFT,
    output logic [W-1:0]       BR,
    output logic [W-1:0]       BRN,
    output logic               SER_OUT,
    output logic               BUSY,
    output logic               DONE,
    output logic               PAR_ERR
);

    localparam int CW = $clog2(W);

    typedef enum logic {IDLE = 1'b0, SHIFTING = 1'b1} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   br_q, br_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           ser_q, ser_d;
    logic           done_q, done_d;
    logic           par_err_q, par_err_d;

    logic [W-1:0]   s_merge;
    logic           any_valid;
    logic           par_ok;

    // Wired-OR of all strobed sense channels; colliding channels simply merge.
    always_comb begin
        s_merge = '0;
        for (int m = 0; m < N_MOD; m++) begin
            if (SA_VALID[m]) s_merge = s_merge | SA[m*W +: W];
        end
    end

    assign any_valid = |SA_VALID;
    // Stored parity bits of strobed modules are ORed as well; odd overall
    // parity (data plus parity bit) is the good case.
    assign par_ok    = (^s_merge) ^ (|(SA_PAR & SA_VALID));

    always_comb begin
        state_d   = state_q;
        br_d      = br_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        par_err_d = par_err_q;

        case (state_q)
            IDLE: begin
                br_d = (br_q & {W{CBRVN}})
                     | s_merge
                     | (TR &  SYL_MASK & {W{SBRYV}})
                     | (TR & ~SYL_MASK & {W{SBRZV}});
                // A detected error takes priority over a clear in the same cycle.
                if (any_valid && !par_ok)
                    par_err_d = 1'b1;
                else if (!CBRVN && !any_valid)
                    par_err_d = 1'b0;
                if (SHIFT) begin
                    state_d = SHIFTING;
                    cnt_d   = CW'(W - 1);
                end
            end
            SHIFTING: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    br_d    = '0;
                end else begin
                    br_d  = {1'b0, br_q[W-1:1]};
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so they line up
        // with BR in the same cycle.
        busy_d = (state_d == SHIFTING);
        ser_d  = busy_d & br_d[0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            br_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            ser_q     <= 1'b0;
            done_q    <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            br_q      <= br_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            ser_q     <= ser_d;
            done_q    <= done_d;
            par_err_q <= par_err_d;
        end
    end

    assign BR      = br_q;
    assign BRN     = ~br_q;
    assign SER_OUT = ser_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PAR_ERR = par_err_q;

endmodule

// File: tb/tb_buffer_register_serial.sv
// Scoreboard bench for buffer_register_serial: stimulus pushes expected
// register snapshots (tagged with the cycle they must appear) and expected
// serial bits; a negedge monitor pops and compares.
module tb_buffer_register_serial;

    localparam int W = 26;
    localparam int N = 4;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           CBRVN = 1'b1;
    logic           SBRZV = 1'b0;
    logic           SBRYV = 1'b0;
    logic [W-1:0]   TR = '0;
    logic [N*W-1:0] SA = '0;
    logic [N-1:0]   SA_VALID = '0;
    logic [N-1:0]   SA_PAR = '0;
    logic           SHIFT = 1'b0;
    logic [W-1:0]   BR, BRN;
    logic           SER_OUT, BUSY, DONE, PAR_ERR;

    buffer_register_serial #(.W(W), .N_MOD(N), .SYL_MASK(26'h3FFE000)) dut (
        .CLK(CLK), .RESET(RESET), .CBRVN(CBRVN), .SBRZV(SBRZV), .SBRYV(SBRYV),
        .TR(TR), .SA(SA), .SA_VALID(SA_VALID), .SA_PAR(SA_PAR), .SHIFT(SHIFT),
        .BR(BR), .BRN(BRN), .SER_OUT(SER_OUT), .BUSY(BUSY), .DONE(DONE),
        .PAR_ERR(PAR_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string        name;
        int           tag;
        logic [W-1:0] br;
        logic         busy;
        logic         done;
        logic         perr;
    } exp_t;

    exp_t exp_q[$];
    logic ser_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t mon_e;
    logic mon_b;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: snapshot checks keyed by cycle, serial bits popped on BUSY.
    always @(negedge CLK) begin
        while (exp_q.size() > 0 && exp_q[0].tag < cyc) begin
            mon_e = exp_q.pop_front();
            checks++; failures++;
            $display("FAIL %s expired: tag=%0d cyc=%0d", mon_e.name, mon_e.tag, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].tag == cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({BR, BRN, BUSY, DONE, PAR_ERR} !== {mon_e.br, ~mon_e.br, mon_e.busy, mon_e.done, mon_e.perr}) begin
                failures++;
                $display("FAIL %s: got BR=%h BRN=%h BUSY=%b DONE=%b PAR_ERR=%b want BR=%h BRN=%h BUSY=%b DONE=%b PAR_ERR=%b",
                         mon_e.name, BR, BRN, BUSY, DONE, PAR_ERR,
                         mon_e.br, ~mon_e.br, mon_e.busy, mon_e.done, mon_e.perr);
            end
        end
        if (BUSY === 1'b1) begin
            checks++;
            if (ser_q.size() == 0) begin
                failures++;
                $display("FAIL ser_extra: BUSY with no expected bit, SER_OUT=%b cyc=%0d", SER_OUT, cyc);
            end else begin
                mon_b = ser_q.pop_front();
                if (SER_OUT !== mon_b) begin
                    failures++;
                    $display("FAIL ser_bit: got %b want %b cyc=%0d", SER_OUT, mon_b, cyc);
                end
            end
        end else begin
            checks++;
            if (SER_OUT !== 1'b0) begin
                failures++;
                $display("FAIL ser_idle: got %b want 0 cyc=%0d", SER_OUT, cyc);
            end
        end
    end

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] d0, d1, d2, d3);
        return {d3, d2, d1, d0};
    endfunction

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic drive(input logic cbrvn, sbrz, sbry, input logic [W-1:0] tr,
                         input logic [N*W-1:0] sa, input logic [N-1:0] sav, sapar,
                         input logic shift, rst);
        CBRVN = cbrvn; SBRZV = sbrz; SBRYV = sbry; TR = tr;
        SA = sa; SA_VALID = sav; SA_PAR = sapar; SHIFT = shift; RESET = rst;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic expect_next(input string name, input logic [W-1:0] br,
                               input logic busy, done, perr);
        exp_t e;
        e.name = name; e.tag = cyc + 1; e.br = br;
        e.busy = busy; e.done = done; e.perr = perr;
        exp_q.push_back(e);
    endtask

    // Issue SHIFT with the given same-cycle loads; word is the value the loads
    // produce. abort >= 0 asserts RESET while bit 'abort' is on SER_OUT.
    // Cycles 5..7 drive loads, a bad-parity read and SHIFT, all to be ignored.
    task automatic do_shift(input string name, input logic cbrvn, sbrz, sbry,
                            input logic [W-1:0] tr, input logic [W-1:0] word,
                            input int abort);
        int  last;
        bit  aborted;
        logic [W-1:0] ones;
        ones = '1;
        aborted = 1'b0;
        drive(cbrvn, sbrz, sbry, tr, '0, '0, '0, 1'b1, 1'b0);
        expect_next({name, "_start"}, word, 1'b1, 1'b0, 1'b0);
        last = (abort < 0) ? W - 1 : abort;
        for (int i = 0; i <= last; i++) ser_q.push_back(word[i]);
        tick();
        for (int k = 1; k <= W; k++) begin
            if (!aborted) begin
                if (abort >= 0 && k == abort + 1) begin
                    drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
                    expect_next({name, "_rst"}, '0, 1'b0, 1'b0, 1'b0);
                    tick();
                    aborted = 1'b1;
                end else begin
                    if (k >= 5 && k <= 7)
                        drive(1'b0, 1'b1, 1'b1, ones, pack(26'h1, 26'h2, '0, '0),
                              4'b0011, 4'b0000, 1'b1, 1'b0);
                    else
                        idle();
                    if (k < W) expect_next({name, "_shift"}, word >> k, 1'b1, 1'b0, 1'b0);
                    else       expect_next({name, "_done"}, '0, 1'b0, 1'b1, 1'b0);
                    tick();
                end
            end
        end
        idle();
        expect_next({name, "_after"}, '0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b1);
        expect_next("reset", '0, 1'b0, 1'b0, 1'b0);
        tick();

        // Sense-amp load with clear: 3 ones, odd parity fine.
        drive(1'b0, 1'b0, 1'b0, '0, pack(26'h7, '0, '0, '0), 4'b0001, 4'b0000, 1'b0, 1'b0);
        expect_next("t1_sa_load", 26'h0000007, 1'b0, 1'b0, 1'b0);
        tick();

        // Syllable loads OR in; Z load with clear overwrites.
        drive(1'b0, 1'b0, 1'b0, '0, pack(26'h1, '0, '0, '0), 4'b0001, 4'b0000, 1'b0, 1'b0);
        expect_next("t2_br1", 26'h0000001, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 26'h3FFFFFF, '0, '0, '0, 1'b0, 1'b0);
        expect_next("t2_y_or", 26'h3FFE001, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 26'h0000002, '0, '0, '0, 1'b0, 1'b0);
        expect_next("t2_z_clr", 26'h0000002, 1'b0, 1'b0, 1'b0);
        tick();

        // Collision merge with even parity: error beats the same-cycle clear.
        drive(1'b0, 1'b0, 1'b0, '0, pack(26'h1, 26'h2, '0, '0), 4'b0011, 4'b0000, 1'b0, 1'b0);
        expect_next("t3_par_err", 26'h0000003, 1'b0, 1'b0, 1'b1);
        tick();
        idle();
        expect_next("t3_sticky", 26'h0000003, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        expect_next("t3_clear", '0, 1'b0, 1'b0, 1'b0);
        tick();

        // Stored parity bit makes an even data count good.
        drive(1'b0, 1'b0, 1'b0, '0, pack('0, '0, 26'h3, '0), 4'b0100, 4'b0100, 1'b0, 1'b0);
        expect_next("par_bit_ok", 26'h0000003, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, pack('0, 26'h1, '0, 26'h2), 4'b1010, 4'b0010, 1'b0, 1'b0);
        expect_next("par_or_ok", 26'h0000003, 1'b0, 1'b0, 1'b0);
        tick();
        // Parity bit of an unstrobed module must not count.
        drive(1'b0, 1'b0, 1'b0, '0, pack(26'h3, '0, '0, '0), 4'b0001, 4'b0010, 1'b0, 1'b0);
        expect_next("par_masked", 26'h0000003, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
        expect_next("par_clear", '0, 1'b0, 1'b0, 1'b0);
        tick();

        // Full shift of an alternating word.
        drive(1'b0, 1'b1, 1'b1, 26'h2AAAAAA, '0, '0, '0, 1'b0, 1'b0);
        expect_next("t4_load", 26'h2AAAAAA, 1'b0, 1'b0, 1'b0);
        tick();
        do_shift("t4", 1'b1, 1'b0, 1'b0, '0, 26'h2AAAAAA, -1);

        // Reset mid-shift, then a fresh full shift.
        drive(1'b0, 1'b1, 1'b1, 26'h1234567, '0, '0, '0, 1'b0, 1'b0);
        expect_next("t5_load", 26'h1234567, 1'b0, 1'b0, 1'b0);
        tick();
        do_shift("t5", 1'b1, 1'b0, 1'b0, '0, 26'h1234567, 10);
        do_shift("t5_restart", 1'b0, 1'b0, 1'b1, 26'h3FFFFFF, 26'h3FFE000, -1);

        // Load and SHIFT in the same cycle.
        do_shift("t6", 1'b0, 1'b1, 1'b0, 26'h0001FFF, 26'h0001FFF, -1);

        idle();
        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL exp_drain: %0d snapshots left, want 0", exp_q.size());
        end
        checks++;
        if (ser_q.size() != 0) begin
            failures++;
            $display("FAIL ser_drain: %0d bits left, want 0", ser_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
